// File: rtl/core_msg_dispatch.sv
// core_msg_dispatch
//   Routes the scheduler's one-word-per-cycle message stream to the shared-bus
//   cores and holds each r0/instruction word until the addressed cores consume it.
//   Tracks which cores are busy with a task and flags protocol misuse.
//
// Ports
//   clk, reset          clock (rising edge), synchronous active-high reset
//   mess_in             message word from the scheduler
//   core_mask_loading   mess_in is the core mask of a new task
//   r0_mask_loading     mess_in is the r0 init mask
//   r0_loading          mess_in is one r0 data word
//   instr_loading       mess_in is one instruction word
//   core_ack            per core: consumed the word presented this cycle
//   core_done           per core: 1-cycle pulse, task finished
//   core_data           held word presented to the cores
//   core_r0_vld         one-hot r0 word valid
//   core_instr_vld      instruction valid for cores still to ack
//   core_reading        per core: nothing pending
//   core_ready          per core: idle (not in a task)
//   proto_err           sticky protocol-error flag
module core_msg_dispatch #(
  parameter int CORE_NUM = 16,
  parameter int BUS_W    = 16,  // masks travel on the bus, so BUS_W must equal CORE_NUM
  parameter int R0_MAX   = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUS_W-1:0]    mess_in,
  input  logic                core_mask_loading,
  input  logic                r0_mask_loading,
  input  logic                r0_loading,
  input  logic                instr_loading,
  input  logic [CORE_NUM-1:0] core_ack,
  input  logic [CORE_NUM-1:0] core_done,
  output logic [BUS_W-1:0]    core_data,
  output logic [CORE_NUM-1:0] core_r0_vld,
  output logic [CORE_NUM-1:0] core_instr_vld,
  output logic [CORE_NUM-1:0] core_reading,
  output logic [CORE_NUM-1:0] core_ready,
  output logic                proto_err
);

  localparam int PTR_W = $clog2(CORE_NUM);
  localparam int CNT_W = $clog2(R0_MAX + 1);

  typedef enum logic [1:0] {IDLE, R0_PEND, INSTR_PEND} state_t;

  state_t state, state_d;

  logic [BUS_W-1:0]    data_q, data_d;
  logic [CORE_NUM-1:0] r0_vld_q, r0_vld_d;
  logic [CORE_NUM-1:0] instr_vld_q, instr_vld_d;
  logic [CORE_NUM-1:0] busy_q, busy_d;
  logic [CORE_NUM-1:0] task_mask_q, task_mask_d;
  logic [CORE_NUM-1:0] r0_mask_q, r0_mask_d;   // r0 targets not yet served
  logic [CORE_NUM-1:0] ack_acc_q, ack_acc_d;
  logic [PTR_W-1:0]    r0_ptr_q, r0_ptr_d;
  logic [CNT_W-1:0]    r0_cnt_q, r0_cnt_d;
  logic                err_q, err_d;

  // Lowest set bit; 0 when the mask is empty (pointer is unused then).
  function automatic logic [PTR_W-1:0] lowest_bit(input logic [CORE_NUM-1:0] m);
    lowest_bit = '0;
    for (int unsigned i = CORE_NUM; i > 0; i--) begin
      if (m[i-1]) lowest_bit = PTR_W'(i - 1);
    end
  endfunction

  // Strobe decode: only a single strobe in IDLE is accepted.
  logic [3:0]          strobes;
  logic                any_strobe;
  logic                multi_strobe;
  logic                legal;
  logic                accept_cm, accept_r0m, accept_r0, accept_instr;
  logic                r0_avail;
  logic                r0_start, instr_start;
  logic                r0_take, instr_done;
  logic [CORE_NUM-1:0] mess_mask;
  logic [CORE_NUM-1:0] r0_onehot;
  logic [CORE_NUM-1:0] acc_next;
  logic [CORE_NUM-1:0] r0_mask_left;

  assign strobes      = {core_mask_loading, r0_mask_loading, r0_loading, instr_loading};
  assign any_strobe   = |strobes;
  assign multi_strobe = $countones(strobes) > 1;
  assign legal        = (state == IDLE) && !multi_strobe;

  assign accept_cm    = legal && core_mask_loading;
  assign accept_r0m   = legal && r0_mask_loading;
  assign accept_r0    = legal && r0_loading;
  assign accept_instr = legal && instr_loading;

  assign mess_mask    = mess_in[CORE_NUM-1:0];
  assign r0_onehot    = CORE_NUM'(1) << r0_ptr_q;
  assign r0_mask_left = r0_mask_q & ~r0_onehot;

  assign r0_avail     = (|r0_mask_q) && (r0_cnt_q < CNT_W'(R0_MAX));
  assign r0_start     = accept_r0 && r0_avail;
  assign instr_start  = accept_instr && (|task_mask_q);

  assign r0_take      = (state == R0_PEND) && core_ack[r0_ptr_q];
  // Acks landing in the completing cycle count towards completion.
  assign acc_next     = ack_acc_q | (core_ack & task_mask_q);
  assign instr_done   = (state == INSTR_PEND) && (acc_next == task_mask_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      data_q      <= '0;
      r0_vld_q    <= '0;
      instr_vld_q <= '0;
      busy_q      <= '0;
      task_mask_q <= '0;
      r0_mask_q   <= '0;
      ack_acc_q   <= '0;
      r0_ptr_q    <= '0;
      r0_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_d;
      data_q      <= data_d;
      r0_vld_q    <= r0_vld_d;
      instr_vld_q <= instr_vld_d;
      busy_q      <= busy_d;
      task_mask_q <= task_mask_d;
      r0_mask_q   <= r0_mask_d;
      ack_acc_q   <= ack_acc_d;
      r0_ptr_q    <= r0_ptr_d;
      r0_cnt_q    <= r0_cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (r0_start)         state_d = R0_PEND;
        else if (instr_start) state_d = INSTR_PEND;
      end
      R0_PEND:    if (r0_take)    state_d = IDLE;
      INSTR_PEND: if (instr_done) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    data_d      = data_q;
    r0_vld_d    = r0_vld_q;
    instr_vld_d = instr_vld_q;
    task_mask_d = task_mask_q;
    r0_mask_d   = r0_mask_q;
    r0_ptr_d    = r0_ptr_q;
    r0_cnt_d    = r0_cnt_q;
    ack_acc_d   = ack_acc_q;

    err_d = err_q
          | (any_strobe && !legal)
          | (accept_r0 && !r0_avail)
          | (accept_instr && !(|task_mask_q));

    // A set in the same cycle as a done for that core keeps it busy.
    busy_d = (busy_q & ~core_done) | (accept_cm ? mess_mask : '0);

    if (accept_cm) task_mask_d = mess_mask;

    if (accept_r0m) begin
      r0_mask_d = mess_mask;
      r0_ptr_d  = lowest_bit(mess_mask);
      r0_cnt_d  = '0;
    end

    unique case (state)
      IDLE: begin
        if (r0_start) begin
          data_d   = mess_in;
          r0_vld_d = r0_onehot;
        end else if (instr_start) begin
          data_d      = mess_in;
          instr_vld_d = task_mask_q;
          ack_acc_d   = '0;
        end
      end
      R0_PEND: begin
        if (r0_take) begin
          r0_vld_d  = '0;
          r0_mask_d = r0_mask_left;
          // Served bits are always the lowest, so the next target is the
          // lowest remaining bit.
          r0_ptr_d  = lowest_bit(r0_mask_left);
          r0_cnt_d  = r0_cnt_q + CNT_W'(1);
        end
      end
      INSTR_PEND: begin
        ack_acc_d   = acc_next;
        instr_vld_d = instr_done ? '0 : (task_mask_q & ~acc_next);
      end
      default: ;
    endcase
  end

  assign core_data      = data_q;
  assign core_r0_vld    = r0_vld_q;
  assign core_instr_vld = instr_vld_q;
  assign core_reading   = ~(r0_vld_q | instr_vld_q);
  assign core_ready     = ~busy_q;
  assign proto_err      = err_q;

endmodule
